ic_bram_cpu_bus_bridge: RTL and testbench

//  Inverse of the CPU-bus-to-BRAM bridge. Accepts a simple BRAM-style client

---
 rtl/ic_bram_cpu_bus_bridge_pkg.sv | 12 +
 rtl/ic_bram_cpu_bus_bridge.sv | 145 ++++++++++++++
 tb/tb_ic_bram_cpu_bus_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ic_bram_cpu_bus_bridge_pkg.sv
// Shared types for the BRAM-client to CPU-bus bridge.
//   state_e : bridge sequencing states (2-bit encoding).
package ic_bram_cpu_bus_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/ic_bram_cpu_bus_bridge.sv
// BRAM-style client port (cen/addr/wdata/wstrb, stall, rdata) driving a CPU req/gnt +
// recv/ack bus. Bus latency is hidden behind bram_stall; writes may optionally be posted.
// Ports:
//   g_clk, g_resetn          : clock, asynchronous active-low reset
//   bram_cen/addr/wdata/wstrb: client request (wstrb != 0 means write)
//   bram_stall               : client must hold request while high
//   bram_rdata, bram_error   : result of the last non-posted transaction
//   err_sticky, err_clr      : posted-write error flag and its clear
//   mem_*                    : CPU bus request/response channel
module ic_bram_cpu_bus_bridge
  import ic_bram_cpu_bus_bridge_pkg::*;
#(
  parameter bit POST_WRITES = 1'b0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        bram_cen,
  input  logic [31:0] bram_addr,
  input  logic [31:0] bram_wdata,
  input  logic [3:0]  bram_wstrb,
  output logic        bram_stall,
  output logic [31:0] bram_rdata,
  output logic        bram_error,
  output logic        err_sticky,
  input  logic        err_clr,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic        mem_recv,
  output logic        mem_ack,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        wen_q, wen_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  logic        sticky_q, sticky_d;

  always_comb begin
    state_d   = state_q;
    pend_wr_d = pend_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    wen_d     = wen_q;
    rdata_d   = rdata_q;
    berr_d    = berr_q;
    sticky_d  = sticky_q;

    unique case (state_q)
      StIdle: begin
        // A new request waits here until any posted write response has drained.
        if (bram_cen && !pend_wr_q) begin
          addr_d  = bram_addr;
          wdata_d = bram_wdata;
          strb_d  = bram_wstrb;
          wen_d   = |bram_wstrb;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          if (wen_q && POST_WRITES) begin
            pend_wr_d = 1'b1;
            state_d   = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem_recv) begin
          if (!wen_q) begin
            rdata_d = mem_rdata;
          end
          berr_d  = mem_error;
          state_d = StDone;
        end
      end
      StDone: begin
        // Single release cycle; an aborted client (cen low) simply drops the result.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Posted-write response can arrive in any state; only REQ sets pend_wr and it
    // is never entered with pend_wr high, so set and clear cannot collide.
    if (err_clr) begin
      sticky_d = 1'b0;
    end
    if (pend_wr_q && mem_recv) begin
      pend_wr_d = 1'b0;
      if (mem_error) begin
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= StIdle;
      pend_wr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      wen_q     <= 1'b0;
      rdata_q   <= '0;
      berr_q    <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_wr_q <= pend_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      wen_q     <= wen_d;
      rdata_q   <= rdata_d;
      berr_q    <= berr_d;
      sticky_q  <= sticky_d;
    end
  end

  // Stall is gated by cen so an idle client sees stall low.
  assign bram_stall = bram_cen && (state_q != StDone);
  assign bram_rdata = rdata_q;
  assign bram_error = berr_q;
  assign err_sticky = sticky_q;
  assign mem_req    = (state_q == StReq);
  assign mem_wen    = wen_q;
  assign mem_strb   = strb_q;
  assign mem_wdata  = wdata_q;
  assign mem_addr   = addr_q;
  assign mem_ack    = (state_q == StWait) || pend_wr_q;

endmodule

// File: tb/tb_ic_bram_cpu_bus_bridge.sv
module tb_ic_bram_cpu_bus_bridge;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        bram_cen;
  logic [31:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_wstrb;
  logic        bram_stall;
  logic [31:0] bram_rdata;
  logic        bram_error;
  logic        err_sticky;
  logic        err_clr;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 g_clk = ~g_clk;

  ic_bram_cpu_bus_bridge #(
    .POST_WRITES(1'b1)
  ) u_dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .bram_cen  (bram_cen),
    .bram_addr (bram_addr),
    .bram_wdata(bram_wdata),
    .bram_wstrb(bram_wstrb),
    .bram_stall(bram_stall),
    .bram_rdata(bram_rdata),
    .bram_error(bram_error),
    .err_sticky(err_sticky),
    .err_clr   (err_clr),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_error (mem_error),
    .mem_rdata (mem_rdata)
  );

  // The bench never responds while a request is still waiting for grant.
  always @(posedge g_clk) begin
    if (g_resetn) begin
      assert (!(mem_req && mem_recv));
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge g_clk);
    #1;
  endtask

  // Posted write from request to accept; leaves cen low in the cycle after accept.
  task automatic posted_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
    nxt();
    bram_cen = 1'b1; bram_addr = a; bram_wdata = d; bram_wstrb = s;
    nxt(); #1;
    check_eq("pw_req", {31'd0, mem_req}, 32'd1);
    check_eq("pw_strb", {28'd0, mem_strb}, {28'd0, s});
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; #1;
    check_eq("pw_accept", {31'd0, bram_stall}, 32'd0);
    nxt();
    bram_cen = 1'b0; bram_wstrb = 4'h0;
  endtask

  initial begin
    g_resetn = 1'b0; bram_cen = 1'b0; bram_addr = '0; bram_wdata = '0; bram_wstrb = '0;
    err_clr = 1'b0; mem_gnt = 1'b0; mem_recv = 1'b0; mem_error = 1'b0; mem_rdata = '0;

    // Reset values
    #12;
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_ack", {31'd0, mem_ack}, 32'd0);
    check_eq("rst_wen", {31'd0, mem_wen}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_rdata", bram_rdata, 32'd0);
    check_eq("rst_sticky", {31'd0, err_sticky}, 32'd0);
    check_eq("rst_stall", {31'd0, bram_stall}, 32'd0);
    g_resetn = 1'b1;

    // Zero-wait read
    nxt();
    bram_cen = 1'b1; bram_addr = 32'h0000_0100; bram_wstrb = 4'h0; #1;
    check_eq("t1_idle_stall", {31'd0, bram_stall}, 32'd1);
    check_eq("t1_idle_req", {31'd0, mem_req}, 32'd0);
    nxt(); #1;
    check_eq("t1_req", {31'd0, mem_req}, 32'd1);
    check_eq("t1_addr", mem_addr, 32'h0000_0100);
    check_eq("t1_wen", {31'd0, mem_wen}, 32'd0);
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; mem_recv = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
    check_eq("t1_req_drop", {31'd0, mem_req}, 32'd0);
    check_eq("t1_wait_ack", {31'd0, mem_ack}, 32'd1);
    check_eq("t1_wait_stall", {31'd0, bram_stall}, 32'd1);
    nxt();
    mem_recv = 1'b0; #1;
    check_eq("t1_done_stall", {31'd0, bram_stall}, 32'd0);
    check_eq("t1_done_ack", {31'd0, mem_ack}, 32'd0);
    nxt();
    bram_cen = 1'b0; #1;
    check_eq("t1_rdata", bram_rdata, 32'hCAFE_F00D);
    check_eq("t1_berr", {31'd0, bram_error}, 32'd0);

    // Read with late grant and late response
    nxt();
    bram_cen = 1'b1; bram_addr = 32'h0000_0A40; #1;
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      check_eq("t2_req_held", {31'd0, mem_req}, 32'd1);
      check_eq("t2_addr_stable", mem_addr, 32'h0000_0A40);
      check_eq("t2_stall", {31'd0, bram_stall}, 32'd1);
      if (i == 3) mem_gnt = 1'b1;
    end
    nxt();
    mem_gnt = 1'b0; #1;
    check_eq("t2_req_drop", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      #1;
      check_eq("t2_wait_ack", {31'd0, mem_ack}, 32'd1);
      check_eq("t2_wait_stall", {31'd0, bram_stall}, 32'd1);
      if (i == 4) begin
        mem_recv = 1'b1; mem_rdata = 32'h1234_5678;
      end
    end
    nxt();
    mem_recv = 1'b0; #1;
    check_eq("t2_done_stall", {31'd0, bram_stall}, 32'd0);
    nxt();
    bram_cen = 1'b0; #1;
    check_eq("t2_rdata", bram_rdata, 32'h1234_5678);

    // Posted write followed by a read that must wait for the write response
    nxt();
    bram_cen = 1'b1; bram_addr = 32'h0000_0200; bram_wdata = 32'h1122_3344;
    bram_wstrb = 4'hF;
    nxt(); #1;
    check_eq("t3_wr_req", {31'd0, mem_req}, 32'd1);
    check_eq("t3_wr_wen", {31'd0, mem_wen}, 32'd1);
    check_eq("t3_wr_strb", {28'd0, mem_strb}, 32'hF);
    check_eq("t3_wr_wdata", mem_wdata, 32'h1122_3344);
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; #1;
    check_eq("t3_wr_accept", {31'd0, bram_stall}, 32'd0);
    check_eq("t3_pend_ack", {31'd0, mem_ack}, 32'd1);
    nxt();
    bram_addr = 32'h0000_0300; bram_wstrb = 4'h0; bram_wdata = '0; #1;
    check_eq("t3_rd_blocked_stall", {31'd0, bram_stall}, 32'd1);
    check_eq("t3_rd_blocked_req", {31'd0, mem_req}, 32'd0);
    nxt(); #1;
    check_eq("t3_rd_blocked_req2", {31'd0, mem_req}, 32'd0);
    check_eq("t3_pend_ack2", {31'd0, mem_ack}, 32'd1);
    nxt();
    mem_recv = 1'b1; #1;
    check_eq("t3_drain_req", {31'd0, mem_req}, 32'd0);
    nxt();
    mem_recv = 1'b0; #1;
    check_eq("t3_drained_ack", {31'd0, mem_ack}, 32'd0);
    check_eq("t3_drained_req", {31'd0, mem_req}, 32'd0);
    check_eq("t3_drained_stall", {31'd0, bram_stall}, 32'd1);
    nxt(); #1;
    check_eq("t3_rd_req", {31'd0, mem_req}, 32'd1);
    check_eq("t3_rd_addr", mem_addr, 32'h0000_0300);
    check_eq("t3_rd_wen", {31'd0, mem_wen}, 32'd0);
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; mem_recv = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    nxt();
    mem_recv = 1'b0; #1;
    check_eq("t3_rd_done", {31'd0, bram_stall}, 32'd0);
    nxt();
    bram_cen = 1'b0; #1;
    check_eq("t3_rd_rdata", bram_rdata, 32'hA5A5_5A5A);
    check_eq("t3_sticky", {31'd0, err_sticky}, 32'd0);

    // Posted write error sets sticky flag, not bram_error
    posted_write(32'h0000_0400, 32'h0000_0055, 4'h1);
    mem_recv = 1'b1; mem_error = 1'b1; #1;
    check_eq("t4_pend_ack", {31'd0, mem_ack}, 32'd1);
    nxt();
    mem_recv = 1'b0; mem_error = 1'b0; #1;
    check_eq("t4_sticky_set", {31'd0, err_sticky}, 32'd1);
    check_eq("t4_berr_clear", {31'd0, bram_error}, 32'd0);
    check_eq("t4_ack_drop", {31'd0, mem_ack}, 32'd0);
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0; #1;
    check_eq("t4_sticky_clr", {31'd0, err_sticky}, 32'd0);
    // Error arriving together with clear: set wins
    posted_write(32'h0000_0404, 32'h0000_AA00, 4'h2);
    mem_recv = 1'b1; mem_error = 1'b1; err_clr = 1'b1;
    nxt();
    mem_recv = 1'b0; mem_error = 1'b0; err_clr = 1'b0; #1;
    check_eq("t4_set_wins", {31'd0, err_sticky}, 32'd1);
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0; #1;
    check_eq("t4_sticky_clr2", {31'd0, err_sticky}, 32'd0);

    // Read with bus error
    nxt();
    bram_cen = 1'b1; bram_addr = 32'h0000_0500; bram_wstrb = 4'h0;
    nxt();
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; mem_recv = 1'b1; mem_error = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    nxt();
    mem_recv = 1'b0; mem_error = 1'b0; #1;
    check_eq("t5_done_stall", {31'd0, bram_stall}, 32'd0);
    nxt();
    bram_cen = 1'b0; #1;
    check_eq("t5_berr", {31'd0, bram_error}, 32'd1);
    check_eq("t5_rdata", bram_rdata, 32'hDEAD_BEEF);
    check_eq("t5_sticky", {31'd0, err_sticky}, 32'd0);

    // Reset asserted while waiting for a response
    nxt();
    bram_cen = 1'b1; bram_addr = 32'h0000_0800;
    nxt();
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; #1;
    check_eq("t6_wait_ack", {31'd0, mem_ack}, 32'd1);
    g_resetn = 1'b0; #1;
    check_eq("t6_rst_ack", {31'd0, mem_ack}, 32'd0);
    check_eq("t6_rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("t6_rst_addr", mem_addr, 32'd0);
    check_eq("t6_rst_rdata", bram_rdata, 32'd0);
    check_eq("t6_rst_berr", {31'd0, bram_error}, 32'd0);
    bram_cen = 1'b0; #1;
    check_eq("t6_rst_stall", {31'd0, bram_stall}, 32'd0);
    nxt();
    g_resetn = 1'b1;
    nxt();
    bram_cen = 1'b1; bram_addr = 32'h0000_0804;
    nxt(); #1;
    check_eq("t6_idle_then_req", {31'd0, mem_req}, 32'd1);
    check_eq("t6_new_addr", mem_addr, 32'h0000_0804);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
